seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_pkg.sv | 34 +++
 rtl/seven_seg_scanner_hex.sv | 14 +
 rtl/seven_seg_scanner.sv | 153 +++++++++++++++
 tb/tb_seven_seg_scanner.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants for the seven-segment scanner.
// Segment patterns are stored active-high in {g,f,e,d,c,b,a} order;
// polarity is applied at the scanner outputs.
package seven_seg_pkg;

  // Entry n is the pattern for hex digit n (entry 15 listed first).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71,  // F: a e f g
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A: a b c e f g
    7'h6F,  // 9
    7'h7F,  // 8: all
    7'h07,  // 7: a b c
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1: b c
    7'h3F   // 0: a b c d e f
  };

  // Bits needed to hold values 0..v-1 (at least 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/seven_seg_scanner_hex.sv
// hex_to_seven_seg: combinational hex nibble to active-high segment decode.
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Table lookup of the active-high pattern
  always_comb begin
    seg = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for N_DIGITS seven-segment digits.
// Optional feature: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to suppress leading
// zeros (digit 0 always shown, a requested decimal point ends suppression).
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned N_DIGITS         = 4,
  parameter int unsigned PRESCALE         = 50000,
  parameter int unsigned BLANK_CYCLES     = 2,
  parameter bit          DIGIT_ACTIVE_LOW = 1'b1,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic [N_DIGITS-1:0]     dp_in,
  input  logic [N_DIGITS-1:0]     blank_mask,
  output logic [N_DIGITS-1:0]     digit,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int unsigned IW = clog2(N_DIGITS);
  localparam int unsigned PW = clog2(PRESCALE);

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  localparam logic [N_DIGITS-1:0] DIGIT_OFF = DIGIT_ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]          SEG_OFF   = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic                DP_OFF    = SEG_ACTIVE_LOW;

  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [3:0]          nib_q, nib_d;
  logic                dpl_q, dpl_d;
  logic                blank_q, blank_d;
  logic                pend_q, pend_d;
  logic [N_DIGITS-1:0] digit_q, digit_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                ft_q, ft_d;

  logic                boundary;
  logic                show;
  logic [6:0]          seg_hi;
  logic [N_DIGITS-1:0] onehot;

  hex_to_seven_seg u_dec (
    .nibble (nib_d),
    .seg    (seg_hi)
  );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] lz_sup;

  // Mark digits inside the leading-zero run, walking down from the MSB
  always_comb begin
    logic run;
    run    = 1'b1;
    lz_sup = '0;
    for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
      run       = run && (value[4*i +: 4] == 4'h0) && !dp_in[i];
      lz_sup[i] = run;
    end
  end
`endif

  // Prescaler, digit index, slot latch and registered output computation
  always_comb begin
    presc_d  = presc_q;
    idx_d    = idx_q;
    nib_d    = nib_q;
    dpl_d    = dpl_q;
    blank_d  = blank_q;
    pend_d   = pend_q;
    ft_d     = 1'b0;
    boundary = 1'b0;

    if (enable) begin
      boundary = (presc_q == PRESC_LAST);
      if (boundary) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        ft_d    = (idx_q == IDX_LAST);
      end else begin
        presc_d = presc_q + 1'b1;
      end
      // After reset no boundary has latched slot 0 yet, so the pending flag
      // loads it on the first enabled cycle, still inside the blank window.
      if (boundary || pend_q) begin
        nib_d   = value[{idx_d, 2'b00} +: 4];
        dpl_d   = dp_in[idx_d];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        blank_d = blank_mask[idx_d] | lz_sup[idx_d];
`else
        blank_d = blank_mask[idx_d];
`endif
        pend_d  = 1'b0;
      end
    end

    // Outputs are derived from next state so they line up with the new slot.
    show   = enable && (presc_d >= BLANK_END) && !blank_d;
    onehot = N_DIGITS'(1) << idx_d;

    digit_d = show ? onehot : '0;
    seg_d   = show ? seg_hi : '0;
    dp_d    = show & dpl_d;

    if (DIGIT_ACTIVE_LOW) digit_d = ~digit_d;
    if (SEG_ACTIVE_LOW) begin
      seg_d = ~seg_d;
      dp_d  = ~dp_d;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc_q <= '0;
      idx_q   <= '0;
      nib_q   <= '0;
      dpl_q   <= 1'b0;
      blank_q <= 1'b1;
      pend_q  <= 1'b1;
      digit_q <= DIGIT_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      ft_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      nib_q   <= nib_d;
      dpl_q   <= dpl_d;
      blank_q <= blank_d;
      pend_q  <= pend_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      ft_q    <= ft_d;
    end
  end

  assign digit      = digit_q;
  assign segments   = seg_q;
  assign dp         = dp_q;
  assign frame_tick = ft_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: scoreboard bench for seven_seg_scanner
// (N_DIGITS=4, PRESCALE=4, BLANK_CYCLES=1, active-low digits and segments).
module tb_seven_seg_scanner;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] val;
  logic [3:0]  dpi;
  logic [3:0]  mask;
  logic [3:0]  digit;
  logic [6:0]  segments;
  logic        dp;
  logic        frame_tick;

  seven_seg_scanner #(
    .N_DIGITS         (4),
    .PRESCALE         (4),
    .BLANK_CYCLES     (1),
    .DIGIT_ACTIVE_LOW (1'b1),
    .SEG_ACTIVE_LOW   (1'b1)
  ) dut (
    .clock      (clk),
    .reset_n    (rst_n),
    .enable     (en),
    .value      (val),
    .dp_in      (dpi),
    .blank_mask (mask),
    .digit      (digit),
    .segments   (segments),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dpo;
    logic       ft;
  } exp_t;

  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  int   m_presc, m_idx;
  logic [3:0] m_nib;
  bit   m_dp, m_blank, m_pend;

  // phase flags for directed checks
  bit track_ticks = 0;
  int last_tick   = -1;
  bit mask_phase  = 0;
  bit chg_phase   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  function automatic bit lz_dark(input int i);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    if (i == 0) return 1'b0;
    for (int j = 3; j >= i; j--) begin
      if (val[j*4 +: 4] != 4'h0 || dpi[j]) return 1'b0;
    end
    return 1'b1;
`else
    return (i < 0);
`endif
  endfunction

  // Advance the model by one rising edge using current inputs; queue expectation
  task automatic model_edge();
    exp_t e;
    bit   bnd;
    bit   lit;
    e.ft = 1'b0;
    lit  = 1'b0;
    if (!rst_n) begin
      m_presc = 0; m_idx = 0; m_pend = 1; m_blank = 1; m_dp = 0; m_nib = 4'h0;
    end else if (en) begin
      bnd = (m_presc == 3);
      if (bnd) begin
        e.ft    = (m_idx == 3);
        m_idx   = (m_idx + 1) % 4;
        m_presc = 0;
      end else begin
        m_presc = m_presc + 1;
      end
      if (bnd || m_pend) begin
        m_nib   = val[m_idx*4 +: 4];
        m_dp    = dpi[m_idx];
        m_blank = mask[m_idx] | lz_dark(m_idx);
        m_pend  = 0;
      end
      lit = (m_presc >= 1) && !m_blank;
    end
    e.dig = lit ? ~(4'b0001 << m_idx) : 4'b1111;
    e.seg = lit ? ~seg_ref(m_nib) : 7'h7F;
    e.dpo = lit ? ~m_dp : 1'b1;
    q.push_back(e);
  endtask

  // One clock: predict, clock, then compare away from the edge
  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    e = q.pop_front();
    chk("digit",      32'(digit),      32'(e.dig));
    chk("segments",   32'(segments),   32'(e.seg));
    chk("dp",         32'(dp),         32'(e.dpo));
    chk("frame_tick", 32'(frame_tick), 32'(e.ft));
    if (track_ticks && frame_tick === 1'b1) begin
      if (last_tick >= 0) chk("tick_period", 32'(cyc - last_tick), 32'd16);
      last_tick = cyc;
    end
    if (mask_phase && m_idx == 2) begin
      chk("mask_digit", 32'(digit),    32'h0F);
      chk("mask_seg",   32'(segments), 32'h7F);
      chk("mask_dp",    32'(dp),       32'h1);
    end
    if (chg_phase && m_idx == 2 && m_presc == 3)
      chk("midslot_keep2", 32'(segments), 32'h24);
    if (chg_phase && m_idx == 3 && m_presc == 2)
      chk("next_shows_F", 32'(segments), 32'h0E);
  endtask

  task automatic run_until(input int idx, input int presc);
    bit reached;
    reached = 0;
    for (int k = 0; k < 64; k++) begin
      if (m_idx == idx && m_presc == presc) begin
        reached = 1;
        break;
      end
      step();
    end
    if (!reached) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; val = 16'h1234; dpi = 4'h0; mask = 4'h0;
    m_presc = 0; m_idx = 0; m_pend = 1; m_blank = 1; m_dp = 0; m_nib = 4'h0;

    repeat (3) step();
    chk("rst_digit", 32'(digit),    32'h0F);
    chk("rst_seg",   32'(segments), 32'h7F);
    chk("rst_ft",    32'(frame_tick), 32'h0);
    rst_n = 1'b1;

    // basic scan with period measurement
    track_ticks = 1;
    repeat (48) step();
    track_ticks = 0;
    chk("tick_seen", 32'(last_tick >= 0), 32'd1);

    // mid-slot value change during index 2
    chg_phase = 1;
    run_until(2, 1);
    val = 16'hFFFF;
    repeat (8) step();
    chg_phase = 0;
    val = 16'h1234;
    repeat (16) step();

    // digit 2 blanked
    mask = 4'b0100;
    mask_phase = 1;
    repeat (20) step();
    mask_phase = 0;
    mask = 4'b0000;
    repeat (8) step();

    // enable low for 10 cycles during index 1
    run_until(1, 1);
    en = 1'b0;
    repeat (10) step();
    en = 1'b1;
    repeat (12) step();

    // decimal points
    dpi = 4'b0101;
    repeat (20) step();
    dpi = 4'b0000;

    // one-cycle reset mid index 3
    run_until(3, 2);
    rst_n = 1'b0;
    step();
    chk("midrst_digit", 32'(digit),      32'h0F);
    chk("midrst_ft",    32'(frame_tick), 32'h0);
    rst_n = 1'b1;
    repeat (20) step();

    // randomized inputs
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        val  = 16'($urandom);
        dpi  = 4'($urandom);
        mask = 4'($urandom) & 4'($urandom);
      end
      en    = ($urandom_range(0, 7) != 0);
      rst_n = ($urandom_range(0, 63) != 0);
      step();
    end
    rst_n = 1'b1; en = 1'b1; mask = 4'h0; dpi = 4'h0;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    val = 16'h0050;
    repeat (24) step();
    val = 16'h0000;
    repeat (24) step();
    val = 16'h0000; dpi = 4'b0100;
    repeat (24) step();
    dpi = 4'h0;
`endif

    repeat (8) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
